// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: one register per binary shift stage, valid/ready on both sides.
// Optional status outputs (out_zero, out_carry) are enabled with `define SHIFT_STATUS_EN.
`timescale 1ns/1ps
module barrel_shifter_pipe #(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic             in_dir,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef SHIFT_STATUS_EN
    ,
    output logic             out_zero,
    output logic             out_carry
`endif
);

    localparam logic [1:0] OpArith = 2'b01;
    localparam logic [1:0] OpRot   = 2'b10;
    localparam logic [1:0] OpPass  = 2'b11;

    // Per-stage registers; control fields are not needed past the last stage.
    logic [WIDTH-1:0] data_q [SHW];
    logic [SHW-1:0]   valid_q;
    logic [SHW-2:0]   dir_q;
    logic [1:0]       op_q   [SHW-1];
    logic [SHW-1:0]   amt_q  [SHW-1];

    // Stage inputs (s_*) and stage results (nx_*).
    logic [WIDTH-1:0] s_data  [SHW];
    logic [WIDTH-1:0] nx_data [SHW];
    logic [SHW-1:0]   s_valid;
    logic [SHW-1:0]   s_dir;
    logic [1:0]       s_op    [SHW];
    logic [SHW-1:0]   s_amt   [SHW];
    logic             stall;

`ifdef SHIFT_STATUS_EN
    logic [SHW-1:0]   carry_q;
    logic [SHW-1:0]   s_carry;
    logic [SHW-1:0]   nx_carry;
    logic             zero_q;
`endif

    assign stall    = valid_q[SHW-1] & ~out_ready;
    assign in_ready = ~stall;

    always_comb begin
        s_data[0]  = in_data;
        s_valid[0] = in_valid;
        s_dir[0]   = in_dir;
        s_op[0]    = in_op;
        s_amt[0]   = in_amt;
`ifdef SHIFT_STATUS_EN
        s_carry[0] = 1'b0;
`endif
        for (int k = 1; k < SHW; k++) begin
            s_data[k]  = data_q[k-1];
            s_valid[k] = valid_q[k-1];
            s_dir[k]   = dir_q[k-1];
            s_op[k]    = op_q[k-1];
            s_amt[k]   = amt_q[k-1];
`ifdef SHIFT_STATUS_EN
            s_carry[k] = carry_q[k-1];
`endif
        end
    end

    // Stage k shifts by 2^k; the carry is the last bit pushed out by the latest active stage.
    always_comb begin
        for (int k = 0; k < SHW; k++) begin
            nx_data[k] = s_data[k];
`ifdef SHIFT_STATUS_EN
            nx_carry[k] = s_carry[k];
`endif
            if (s_amt[k][k] && (s_op[k] != OpPass)) begin
                if (s_op[k] == OpRot) begin
                    if (s_dir[k]) begin
                        nx_data[k] = (s_data[k] << (1 << k)) | (s_data[k] >> (WIDTH - (1 << k)));
                    end else begin
                        nx_data[k] = (s_data[k] >> (1 << k)) | (s_data[k] << (WIDTH - (1 << k)));
                    end
                end else if (s_dir[k]) begin
                    nx_data[k] = s_data[k] << (1 << k);
`ifdef SHIFT_STATUS_EN
                    nx_carry[k] = s_data[k][WIDTH-(1<<k)];
`endif
                end else begin
                    if (s_op[k] == OpArith) begin
                        nx_data[k] = $signed(s_data[k]) >>> (1 << k);
                    end else begin
                        nx_data[k] = s_data[k] >> (1 << k);
                    end
`ifdef SHIFT_STATUS_EN
                    nx_carry[k] = s_data[k][(1<<k)-1];
`endif
                end
            end
        end
    end

    // Stages load only on a valid beat, so the output holds across bubbles and stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dir_q   <= '0;
            for (int k = 0; k < SHW; k++) begin
                data_q[k] <= '0;
            end
            for (int k = 0; k < SHW - 1; k++) begin
                op_q[k]  <= '0;
                amt_q[k] <= '0;
            end
`ifdef SHIFT_STATUS_EN
            carry_q <= '0;
            zero_q  <= 1'b0;
`endif
        end else if (!stall) begin
            valid_q <= s_valid;
            for (int k = 0; k < SHW; k++) begin
                if (s_valid[k]) begin
                    data_q[k] <= nx_data[k];
`ifdef SHIFT_STATUS_EN
                    carry_q[k] <= nx_carry[k];
`endif
                end
            end
            for (int k = 0; k < SHW - 1; k++) begin
                if (s_valid[k]) begin
                    dir_q[k] <= s_dir[k];
                    op_q[k]  <= s_op[k];
                    amt_q[k] <= s_amt[k];
                end
            end
`ifdef SHIFT_STATUS_EN
            if (s_valid[SHW-1]) begin
                zero_q <= (nx_data[SHW-1] == '0);
            end
`endif
        end
    end

    assign out_valid = valid_q[SHW-1];
    assign out_data  = data_q[SHW-1];
`ifdef SHIFT_STATUS_EN
    assign out_zero  = zero_q;
    assign out_carry = carry_q[SHW-1];
`endif

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Self-checking bench for barrel_shifter_pipe: an 8-bit and a 32-bit instance driven from
// directed vector tables, plus stall, random-stream and mid-flight reset sequences.
`timescale 1ns/1ps
module tb_barrel_shifter_pipe;

    typedef struct {
        logic [31:0] d;
        int          a;
        logic        dir;
        logic [1:0]  op;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        int          t;
        logic        c;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic lat8 = 1'b1;
    logic lat32 = 1'b1;

    logic       a8_in_valid = 1'b0, a8_in_ready, a8_in_dir = 1'b0;
    logic       a8_out_valid, a8_out_ready = 1'b1;
    logic [7:0] a8_in_data = '0, a8_out_data;
    logic [2:0] a8_in_amt = '0;
    logic [1:0] a8_in_op = '0;
    logic [31:0] a8_exp = '0;
    logic        a8_expc = 1'b0;

    logic        b32_in_valid = 1'b0, b32_in_ready, b32_in_dir = 1'b0;
    logic        b32_out_valid, b32_out_ready = 1'b1;
    logic [31:0] b32_in_data = '0, b32_out_data;
    logic [4:0]  b32_in_amt = '0;
    logic [1:0]  b32_in_op = '0;
    logic [31:0] b32_exp = '0;
    logic        b32_expc = 1'b0;

`ifdef SHIFT_STATUS_EN
    logic a8_zero, a8_carry, b32_zero, b32_carry;
`endif

    exp_t q8[$];
    exp_t q32[$];
    exp_t e8, e32;
    vec_t v8[15];
    vec_t v32[12];

    barrel_shifter_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a8_in_valid), .in_ready(a8_in_ready), .in_data(a8_in_data),
        .in_amt(a8_in_amt), .in_dir(a8_in_dir), .in_op(a8_in_op),
        .out_valid(a8_out_valid), .out_ready(a8_out_ready), .out_data(a8_out_data)
`ifdef SHIFT_STATUS_EN
        , .out_zero(a8_zero), .out_carry(a8_carry)
`endif
    );

    barrel_shifter_pipe #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b32_in_valid), .in_ready(b32_in_ready), .in_data(b32_in_data),
        .in_amt(b32_in_amt), .in_dir(b32_in_dir), .in_op(b32_in_op),
        .out_valid(b32_out_valid), .out_ready(b32_out_ready), .out_data(b32_out_data)
`ifdef SHIFT_STATUS_EN
        , .out_zero(b32_zero), .out_carry(b32_carry)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref32(input logic [31:0] d, input int n, input logic dir,
                                          input logic [1:0] op);
        if (op == 2'b11 || n == 0) return d;
        if (op == 2'b10) return dir ? ((d << n) | (d >> (32 - n))) : ((d >> n) | (d << (32 - n)));
        if (dir) return d << n;
        if (op == 2'b01) return $signed(d) >>> n;
        return d >> n;
    endfunction

    function automatic logic cref(input logic [31:0] d, input int w, input int n, input logic dir,
                                  input logic [1:0] op);
        if (n == 0 || op[1]) return 1'b0;
        return dir ? d[w-n] : d[n-1];
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (a8_out_valid && a8_out_ready) begin
                if (q8.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL w8 spurious output: got %h, expected none", a8_out_data);
                end else begin
                    e8 = q8.pop_front();
                    chk("w8 data", {24'b0, a8_out_data}, e8.d);
                    if (lat8) chk("w8 latency", 32'(cyc - e8.t), 32'd3);
`ifdef SHIFT_STATUS_EN
                    chk("w8 carry", {31'b0, a8_carry}, {31'b0, e8.c});
                    chk("w8 zero", {31'b0, a8_zero}, {31'b0, e8.d == 32'd0});
`endif
                end
            end
            if (a8_in_valid && a8_in_ready) q8.push_back('{a8_exp, cyc, a8_expc});
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (b32_out_valid && b32_out_ready) begin
                if (q32.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL w32 spurious output: got %h, expected none", b32_out_data);
                end else begin
                    e32 = q32.pop_front();
                    chk("w32 data", b32_out_data, e32.d);
                    if (lat32) chk("w32 latency", 32'(cyc - e32.t), 32'd5);
`ifdef SHIFT_STATUS_EN
                    chk("w32 carry", {31'b0, b32_carry}, {31'b0, e32.c});
                    chk("w32 zero", {31'b0, b32_zero}, {31'b0, e32.d == 32'd0});
`endif
                end
            end
            if (b32_in_valid && b32_in_ready) q32.push_back('{b32_exp, cyc, b32_expc});
        end
    end

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send8(input vec_t v);
        int n = 0;
        a8_in_data = v.d[7:0]; a8_in_amt = 3'(v.a); a8_in_dir = v.dir; a8_in_op = v.op;
        a8_exp = v.exp; a8_expc = cref(v.d, 8, v.a, v.dir, v.op);
        a8_in_valid = 1'b1;
        do begin @(negedge clk); n++; end while (!a8_in_ready && n < 200);
        if (!a8_in_ready) begin
            checks++; errors++;
            $display("FAIL w8 send timeout: in_ready %b, expected 1", a8_in_ready);
        end
        @(posedge clk); #1;
        a8_in_valid = 1'b0;
    endtask

    task automatic send32(input vec_t v);
        int n = 0;
        b32_in_data = v.d; b32_in_amt = 5'(v.a); b32_in_dir = v.dir; b32_in_op = v.op;
        b32_exp = v.exp; b32_expc = cref(v.d, 32, v.a, v.dir, v.op);
        b32_in_valid = 1'b1;
        do begin @(negedge clk); n++; end while (!b32_in_ready && n < 200);
        if (!b32_in_ready) begin
            checks++; errors++;
            $display("FAIL w32 send timeout: in_ready %b, expected 1", b32_in_ready);
        end
        @(posedge clk); #1;
        b32_in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (q8.size() + q32.size() != 0); i++) @(posedge clk);
        #1;
        chk("drain pending results", 32'(q8.size() + q32.size()), 32'd0);
    endtask

    initial begin
        vec_t v;
        v8[0]  = '{32'h96, 3, 1'b1, 2'b00, 32'hB0};
        v8[1]  = '{32'h96, 3, 1'b0, 2'b00, 32'h12};
        v8[2]  = '{32'h96, 3, 1'b0, 2'b01, 32'hF2};
        v8[3]  = '{32'h96, 3, 1'b1, 2'b10, 32'hB4};
        v8[4]  = '{32'h5A, 0, 1'b1, 2'b00, 32'h5A};
        v8[5]  = '{32'h5A, 0, 1'b0, 2'b01, 32'h5A};
        v8[6]  = '{32'h5A, 0, 1'b1, 2'b10, 32'h5A};
        v8[7]  = '{32'h5A, 0, 1'b0, 2'b11, 32'h5A};
        v8[8]  = '{32'hC3, 7, 1'b1, 2'b11, 32'hC3};
        v8[9]  = '{32'h96, 1, 1'b0, 2'b10, 32'h4B};
        v8[10] = '{32'h96, 2, 1'b1, 2'b01, 32'h58};
        v8[11] = '{32'h7F, 4, 1'b0, 2'b01, 32'h07};
        v8[12] = '{32'h81, 7, 1'b1, 2'b10, 32'hC0};
        v8[13] = '{32'h81, 1, 1'b1, 2'b00, 32'h02};
        v8[14] = '{32'h01, 1, 1'b0, 2'b00, 32'h00};

        v32[0]  = '{32'h8000_0000, 31, 1'b0, 2'b01, 32'hFFFF_FFFF};
        v32[1]  = '{32'h0000_0001,  1, 1'b0, 2'b10, 32'h8000_0000};
        v32[2]  = '{32'h1234_5678,  4, 1'b1, 2'b00, 32'h2345_6780};
        v32[3]  = '{32'h1234_5678,  8, 1'b0, 2'b00, 32'h0012_3456};
        v32[4]  = '{32'h1234_5678,  8, 1'b1, 2'b10, 32'h3456_7812};
        v32[5]  = '{32'hF000_000F,  4, 1'b0, 2'b10, 32'hFF00_0000};
        v32[6]  = '{32'h8765_4321,  4, 1'b0, 2'b01, 32'hF876_5432};
        v32[7]  = '{32'h8765_4321, 17, 1'b1, 2'b11, 32'h8765_4321};
        v32[8]  = '{32'h0000_0001, 31, 1'b1, 2'b00, 32'h8000_0000};
        v32[9]  = '{32'hDEAD_BEEF,  0, 1'b0, 2'b01, 32'hDEAD_BEEF};
        v32[10] = '{32'h4000_0000, 30, 1'b0, 2'b01, 32'h0000_0001};
        v32[11] = '{32'hFFFF_FFFF, 31, 1'b0, 2'b00, 32'h0000_0001};

        #7;
        chk("reset w8 out_valid", {31'b0, a8_out_valid}, 32'd0);
        chk("reset w8 out_data", {24'b0, a8_out_data}, 32'd0);
        chk("reset w32 out_valid", {31'b0, b32_out_valid}, 32'd0);
        chk("reset w32 out_data", b32_out_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("idle w8 in_ready", {31'b0, a8_in_ready}, 32'd1);

        // Directed 8-bit vectors, streamed back to back.
        for (int i = 0; i < 15; i++) send8(v8[i]);
        drain();

        // Stall with a full pipe: hold six cycles, then release and let the monitor check order.
        lat8 = 1'b0;
        a8_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send8(v8[i]);
        fork
            send8(v8[3]);
            begin
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    chk("stall in_ready", {31'b0, a8_in_ready}, 32'd0);
                    chk("stall out_valid", {31'b0, a8_out_valid}, 32'd1);
                    chk("stall out_data", {24'b0, a8_out_data}, 32'hB0);
                end
                @(posedge clk); #1;
                a8_out_ready = 1'b1;
            end
        join
        drain();
        lat8 = 1'b1;

        // 32-bit boundaries, then a random back-to-back stream against the reference model.
        for (int i = 0; i < 12; i++) send32(v32[i]);
        for (int i = 0; i < 100; i++) begin
            v.d   = $urandom();
            v.a   = int'($urandom_range(0, 31));
            v.dir = 1'($urandom_range(0, 1));
            v.op  = 2'($urandom_range(0, 3));
            v.exp = ref32(v.d, v.a, v.dir, v.op);
            send32(v);
        end
        drain();

        // Asynchronous reset with three ops in flight.
        for (int i = 0; i < 3; i++) send8(v8[4+i]);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst out_valid", {31'b0, a8_out_valid}, 32'd0);
        chk("async rst out_data", {24'b0, a8_out_data}, 32'd0);
        q8.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post-reset out_valid", {31'b0, a8_out_valid}, 32'd0);
        end
        @(posedge clk); #1;
        send8(v8[9]);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/barrel_shifter_pipe.md
Name: barrel_shifter_pipe

Overview:
- Parametrised, pipelined barrel shifter. Successor to the 8-bit combinational left/right shifter.
- Adds arbitrary power-of-two width, arithmetic shift and rotate modes, one register per binary shift stage, and a valid/ready handshake on both sides.
- Sits between operand sources and the ALU result mux in the datapath.

Parameters:
- WIDTH, 32, data width in bits. Must be a power of two, >= 4.
- SHW, $clog2(WIDTH), shift-amount width and pipeline depth. Derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input operand valid
- in_ready  output  1  block can accept the operand this cycle
- in_data  input  WIDTH  operand
- in_amt  input  SHW  shift amount, 0..WIDTH-1
- in_dir  input  1  1 = left, 0 = right
- in_op  input  2  00 logical, 01 arithmetic, 10 rotate, 11 pass-through
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  WIDTH  result

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, all internal stage valids=0, all stage data=0. Any in-flight operations are discarded with no output.
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Pipeline structure:
  - SHW register stages. Stage k (k=0..SHW-1) applies a shift of 2^k when in_amt bit k is 1.
  - Stage 0 is registered directly from the inputs.
  - dir, op and the remaining amount bits travel with the data.
- Latency is exactly SHW cycles from input transfer to out_valid, with no stalls. Throughput is 1 op/cycle.
- Stall control:
  - stall = out_valid && !out_ready.
  - in_ready = !stall. This is combinational, with no dependency on in_valid.
  - While stall is asserted, every stage holds data and valid.
  - Bubbles are not collapsed during stall.
- Op semantics (n = in_amt):
  - Logical left: data << n, zero fill.
  - Logical right: data >> n, zero fill.
  - Arithmetic right: shift right with sign (in_data[WIDTH-1]) replicated into the vacated bits.
  - Arithmetic left: identical to logical left.
  - Rotate left: bits shifted out of the MSB re-enter at the LSB. Rotate right is the mirror image.
  - Pass-through (op 11): out_data = in_data for any amt/dir, with the same latency.
- n=0 for any op: out_data = in_data.
- out_data changes only on the cycle a new valid result reaches the last stage. It holds its value while out_valid=0 and during stall.
- Order is strictly preserved. No result is dropped or duplicated under any out_ready pattern.
- Simultaneous input and output transfer in the same cycle is supported at full rate.
- in_amt is SHW bits wide, so out-of-range amounts cannot be encoded.

Optional Feature:
- Macro: SHIFT_STATUS_EN.
- When defined, adds two output ports, out_zero (1 bit) and out_carry (1 bit). Both are registered alongside out_data, reset to 0, and are valid with out_valid.
  - out_zero = (out_data == 0).
  - out_carry = last bit shifted out:
    - Left shift with n>0: in_data[WIDTH-n].
    - Right shift (logical/arith) with n>0: in_data[n-1].
    - Otherwise (n=0, rotate, pass-through): 0.
- When not defined, the ports and logic are absent. Data behaviour and latency are unchanged.

Test Plan:
1. WIDTH=8, out_ready=1. Apply data=8'b1001_0110 in successive cycles with (amt=3, left logical), (amt=3, right logical), (amt=3, right arith), (amt=3, left rotate). Expected results, each 3 cycles after its input transfer: 8'b1011_0000, 8'b0001_0010, 8'b1111_0010, 8'b1011_0100.
2. WIDTH=32, 100 back-to-back random ops with out_ready=1 -> one result per cycle after a 5-cycle latency, all matching the reference model, in order.
3. WIDTH=8, out_ready held 0 for 6 cycles with a full pipe -> in_ready=0, out_data/out_valid stable. On release, all queued results emerge in order with none lost.
4. Boundaries: amt=0 with each op -> out=in. Op 11 with amt=7 -> out=in. Arith right of 32'h8000_0000 by 31 -> 32'hFFFF_FFFF. Rotate right of 32'h0000_0001 by 1 -> 32'h8000_0000.
5. Assert rst_n=0 asynchronously mid-flight with 3 ops in the pipe -> out_valid=0 and out_data=0 immediately. No stale result appears after release. The next op completes after SHW cycles.
6. With SHIFT_STATUS_EN, WIDTH=8: 8'h81 logical left by 1 -> out_data=8'h02, out_carry=1, out_zero=0. 8'h01 logical right by 1 -> out_data=8'h00, out_carry=1, out_zero=1.
